// File: rtl/post_rx_fifo.sv
// POST pulse-code receiver: decodes testreq pulse groups into words and queues them in a FWFT FIFO.
// Define POSTCODE_ERRCNT_EN to implement the saturating protocol error counter on err_count.
module post_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int BREAK_CYCLES = 50
) (
  input  logic              refclk,
  input  logic              reset_n,
  input  logic              testreq,
  output logic              testack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              fifo_full,
  output logic              overflow,
  output logic [7:0]        err_count
);

  localparam int LW = $clog2(BREAK_CYCLES + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {UNSYNC, SYNCED, OUTPUT, HOLD} state_t;

  logic          sync1, sync2, sync3;
  logic          rise;
  logic [4:0]    pulse_cnt;
  logic [LW-1:0] low_run;
  logic          close;
  logic [4:0]    n;

  state_t            state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [BW-1:0]     bit_idx, bit_d;
  logic              wr_en, ovf_set, testack_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_d;
  logic              pop;

  // Input synchroniser plus one extra flop for rising-edge detection.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= testreq;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise  = sync2 & ~sync3;
  assign n     = pulse_cnt;
  assign close = ~sync2 && (low_run == LW'(BREAK_CYCLES - 1)) && (pulse_cnt != 5'd0);

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
      low_run   <= '0;
    end else begin
      if (sync2)
        low_run <= '0;
      else if (low_run != LW'(BREAK_CYCLES))
        low_run <= low_run + 1'b1;

      if (close)
        pulse_cnt <= '0;
      else if (rise && pulse_cnt != 5'd31)
        pulse_cnt <= pulse_cnt + 5'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= UNSYNC;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_idx <= bit_d;
    end
  end

  // FSM: next state, word assembly and commit decisions
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d   = bit_idx;
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    if (close) begin
      if (n == 5'd4) begin
        state_d = SYNCED;
        shift_d = '0;
        bit_d   = '0;
      end else begin
        case (state)
          UNSYNC: ;
          SYNCED: begin
            if (n == 5'd3) begin
              state_d = OUTPUT;
              shift_d = '0;
              bit_d   = '0;
            end
          end
          OUTPUT: begin
            if (n == 5'd1 || n == 5'd2) begin
              shift_d = (shift << 1) | DATA_W'(n == 5'd2);
              if (bit_idx == BW'(DATA_W - 1))
                state_d = HOLD;
              else
                bit_d = bit_idx + 1'b1;
            end else begin
              state_d = SYNCED;
              shift_d = '0;
              bit_d   = '0;
            end
          end
          HOLD: begin
            state_d = SYNCED;
            shift_d = '0;
            bit_d   = '0;
            if (n == 5'd12) begin
              // A pop in the same cycle frees a slot even when full.
              if (!fifo_full || pop)
                wr_en = 1'b1;
              else
                ovf_set = 1'b1;
            end
          end
          default: state_d = UNSYNC;
        endcase
      end
    end
  end

  // FSM: outputs
  always_comb begin
    testack_d = ((state == OUTPUT) || (state == HOLD)) && !fifo_full;
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      testack  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      testack <= testack_d;
      if (ovf_set)
        overflow <= 1'b1;
    end
  end

  // Committed-word FIFO, first-word-fall-through.
  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_d = count;
    case ({wr_en, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (wr_en)
      mem[wr_ptr] <= shift;
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_d;
      fifo_full <= (count_d == (AW + 1)'(FIFO_DEPTH));
    end
  end

`ifdef POSTCODE_ERRCNT_EN
  logic err_inc;

  assign err_inc = close && (n != 5'd4) &&
                   (((state == SYNCED) && (n != 5'd3)) ||
                    ((state == OUTPUT) && (n != 5'd1) && (n != 5'd2)) ||
                    ((state == HOLD) && ((n != 5'd12) || (fifo_full && !pop))));

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (err_inc && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
